// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier.
// Each BUSY cycle retires one Booth digit: the partial product {0, +-A, +-2A}
// is shifted into place and added to a modular accumulator of 2*WIDTH+2 bits.
// valid/ready handshakes on both sides; out_p is held in its own register so
// it stays stable in DONE and keeps its last value back in IDLE.
module booth_r4_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy
);

    localparam int NDIG = WIDTH / 2 + 1;   // Booth digits per product
    localparam int AW   = WIDTH + 2;       // extended multiplicand, holds +-2A
    localparam int BW   = WIDTH + 3;       // {ext, ext, b, 1'b0}
    localparam int PW   = 2 * WIDTH + 2;   // accumulator width
    localparam int CW   = $clog2(NDIG + 1);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("booth_r4_seq_mult: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       a_q, a_d;
    logic [BW-1:0]       b_q, b_d;
    logic [PW-1:0]       acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  p_q, p_d;

    logic [AW-1:0]       pp;
    logic [PW-1:0]       pp_shifted;
    logic                a_ext;
    logic                b_ext;

    // Booth digit decode: b_q is shifted right by two each iteration, so the
    // current digit always sits in the low three bits.
    always_comb begin
        pp = '0;
        case (b_q[2:0])
            3'b001, 3'b010: pp = a_q;
            3'b011:         pp = a_q << 1;
            3'b100:         pp = -(a_q << 1);
            3'b101, 3'b110: pp = -a_q;
            default:        pp = '0;
        endcase
        pp_shifted = {{WIDTH{pp[AW-1]}}, pp} << {cnt_q, 1'b0};
    end

    // Extension bits for the latched operands, chosen by the operand mode.
    assign a_ext = in_signed & in_a[WIDTH-1];
    assign b_ext = in_signed & in_b[WIDTH-1];

    // Next-state and datapath update; every target holds its value by default.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = {{2{a_ext}}, in_a};
                    b_d     = {{2{b_ext}}, in_b, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = acc_q + pp_shifted;
                b_d   = b_q >> 2;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NDIG - 1)) begin
                    p_d     = acc_d[2*WIDTH-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_p     = p_q;

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Directed and randomised checks for booth_r4_seq_mult at WIDTH=8.
module tb_booth_r4_seq_mult;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    booth_r4_seq_mult #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One transaction: accept, measure latency, optional stall with junk
    // in_valid pulses, check product, handshake, check return to IDLE.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [15:0] exp, input int stall,
                          input logic junk);
        int cyc;
        logic [15:0] held;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_a = a; in_b = b; in_signed = s; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            if (junk) begin
                in_valid = 1'b1; in_a = ~a; in_b = b ^ 8'h5A;
            end
            @(posedge clk); #1; cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'd5);
        held = out_p;
        for (int i = 0; i < stall; i++) begin
            if (junk) in_valid = i[0];
            @(posedge clk); #1;
            chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_stall_p"}, 32'(out_p), 32'(held));
            if (junk) chk({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        chk({tag, "_product"}, 32'(out_p), 32'(exp));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_post_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_post_p"}, 32'(out_p), 32'(exp));
    endtask

    initial begin
        int cnt;
        logic [7:0] ra, rb;
        logic rs;
        byte sa, sb;
        int prod;
        int ua, ub;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_p", 32'(out_p), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        run_op("s_m3x5",    8'hFD, 8'h05, 1'b1, 16'hFFF1, 0, 1'b0);
        run_op("s_m128sq",  8'h80, 8'h80, 1'b1, 16'h4000, 0, 1'b0);
        run_op("s_m128x127",8'h80, 8'h7F, 1'b1, 16'hC080, 0, 1'b0);
        run_op("u_255sq",   8'hFF, 8'hFF, 1'b0, 16'hFE01, 0, 1'b0);
        run_op("u_80x81",   8'h80, 8'h81, 1'b0, 16'h4080, 0, 1'b0);
        run_op("s_zero",    8'h00, 8'h9C, 1'b1, 16'h0000, 0, 1'b0);
        run_op("s_m1xm1",   8'hFF, 8'hFF, 1'b1, 16'h0001, 0, 1'b0);
        run_op("bp_12x13",  8'h0C, 8'h0D, 1'b0, 16'h009C, 10, 1'b1);

        // Reset in the middle of iteration 2 aborts the product.
        in_a = 8'h55; in_b = 8'h33; in_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_out_p", 32'(out_p), 32'd0);
        #2 rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid || busy) cnt++;
        end
        chk("arst_no_output", 32'(cnt), 32'd0);
        run_op("post_rst_7x6", 8'h07, 8'h06, 1'b1, 16'h002A, 0, 1'b0);

        // Random pairs against an independent integer reference.
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            if (rs) begin
                sa = ra; sb = rb; prod = sa * sb;
            end else begin
                ua = ra; ub = rb; prod = ua * ub;
            end
            run_op(rs ? "rnd_s" : "rnd_u", ra, rb, rs, prod[15:0],
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
